out_display_unit: RTL and testbench
===================================

Name: out_display_unit

Overview:
- Consumes the processor's OUT-instruction interface (outval1, outval2, outsel, outdisplay) and holds the values for display.
- Keeps an 8-slot bank of captured 32-bit values, each {outval1, outval2}.
- Time-multiplexes one slot, chosen by the board switches, onto an 8-digit active-low 7-segment display.
- Sits directly downstream of the processor, between the pipeline's output stage and the board pins.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit dwell; legal range 1..2^20.
- NUM_DIGITS, 8: number of multiplexed digits; fixed at 8 (32 bits = 8 hex nibbles).

Ports:
- clock  in  1  system clock, same clock as the processor
- reset_n  in  1  asynchronous active-low reset
- outval1  in  16  processor output value 1 (AR of the OUT instruction)
- outval2  in  16  processor output value 2 (BR of the OUT instruction)
- outsel  in  3  destination slot index for the OUT instruction
- outdisplay  in  1  one-cycle strobe; capture request
- freeze  in  1  when 1, capture requests are ignored
- disp_sel  in  3  slot shown on the display
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_n  out  1  decimal point, active-low
- an_n  out  8  digit enables, active-low, an_n[0] = rightmost digit
- slot_valid  out  8  bit i = 1 once slot i has been written since reset
- cap_count  out  16  number of accepted captures, wraps at 0xFFFF -> 0

Behaviour:
- Reset (reset_n low, asynchronous, dominates everything):
  - all slot registers 0; slot_valid = 0; cap_count = 0
  - prescaler = 0; digit index = 0; latched display select = 0
  - an_n = 8'hFF; seg_n = 7'h7F; dp_n = 1
- Capture:
  - On a rising edge with outdisplay=1 and freeze=0: slot[outsel] <= {outval1, outval2}, slot_valid[outsel] <= 1, cap_count += 1.
  - Visible one cycle after the strobe edge. No handshake: every accepted strobe is consumed that cycle.
  - Back-to-back strobes on consecutive cycles are all captured. Repeated writes to the same slot: last write wins.
  - freeze=1: the strobe is dropped; no state changes.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, digit index advances 0..7 and wraps 7 -> 0.
  - SCAN_DIV=1: digit advances every cycle.
- Frame select:
  - disp_sel is sampled into the latched display select only when the digit index wraps 7 -> 0.
  - A frame is never torn across two slots. After reset the first frame shows slot 0.
- Digit drive:
  - Outputs are registered and change one cycle after the index update.
  - an_n = ~(1 << index); exactly one digit is low outside reset.
  - Nibble = slot[latched select][4*index +: 4], decoded to standard hex 7-seg glyphs (0-9, A, b, C, d, E, F).
  - Digit 4 carries the boundary between outval1 and outval2: dp_n = 0 when index == 4 and the slot is valid, else 1.
- Invalid slot: if slot_valid[latched select] = 0, seg_n = 7'h7F and dp_n = 1 for the whole frame; an_n still scans.
- Capture into the currently displayed slot mid-frame: the remaining digits of that frame show the new value. This is accepted behaviour.
- Reset asserted mid-frame: immediate blank per the reset values above. After release, scanning restarts at digit 0 / slot 0.

Decomposition:
- Package simple_ps_pkg:
  - SEG_BLANK = 7'h7F
  - 16-entry hex glyph constant table (active-low)
  - NUM_SLOTS = 8
  - SLOT_W = 32
- Sub-module hex_to_seg7: purely combinational, 4-bit nibble in -> 7-bit active-low segments out, uses the package table. Instantiated once after the nibble mux.
- Everything else (slot bank, prescaler, scan FSM, output registers) stays in out_display_unit.

Test Plan (SCAN_DIV=2 for all cases):
- Reset then release, no strobes -> an_n cycles FE,FD,FB,...,7F, two cycles per digit; seg_n = 7F and dp_n = 1 throughout; slot_valid = 00; cap_count = 0.
- outval1=16'h1234, outval2=16'hABCD, outsel=0, one-cycle strobe -> slot_valid = 01, cap_count = 1.
  - Next frame, digits 0..7 show D, C, b, A, 4, 3, 2, 1; glyph for 'D' = 7'b0100001.
  - dp_n = 0 only while an_n = EF (digit 4).
- Strobes on 3 consecutive cycles to slots 3, 3, 5 with values 0001/0002, 0003/0004, 0005/0006 -> slot3 = 32'h00030004, slot5 = 32'h00050006, slot_valid = 28, cap_count = 3.
- freeze=1 during a strobe to slot 2 -> slot_valid[2] stays 0 and cap_count is unchanged; a later strobe with freeze=0 is accepted.
- Change disp_sel from 0 to 5 while the digit index is 3 -> digits 3..7 still show slot 0; slot 5 appears starting at the next digit 0.
- cap_count preloaded to FFFF via 65535 strobes, then one more strobe -> cap_count = 0000. Assert reset_n low mid-digit -> an_n = FF asynchronously, before the next clock edge.

Source files
------------

// File: rtl/simple_ps_pkg.sv
// Shared constants for the OUT-instruction display path: slot bank geometry
// and the active-low hex glyph table for a {g,f,e,d,c,b,a} 7-segment digit.
package simple_ps_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 32;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index 0 sits at the least significant end, so the list reads F down to 0.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [7:0] digit_enable_n(input logic [2:0] idx);
        return ~(8'b0000_0001 << idx);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-glyph decoder for one active-low 7-segment digit.
module hex_to_seg7
    import simple_ps_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    // Table lookup of the glyph for the selected nibble.
    always_comb begin
        seg_n_o = HEX_GLYPH[nibble_i];
    end

endmodule

// File: rtl/out_display_unit.sv
// Captures OUT-instruction values into an 8-slot bank and scans one slot,
// chosen per frame by the switches, onto an 8-digit active-low display.
module out_display_unit
    import simple_ps_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] outval1,
    input  logic [15:0] outval2,
    input  logic [2:0]  outsel,
    input  logic        outdisplay,
    input  logic        freeze,
    input  logic [2:0]  disp_sel,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  an_n,
    output logic [7:0]  slot_valid,
    output logic [15:0] cap_count
);

    localparam logic [19:0] PRE_LAST   = 20'(SCAN_DIV - 1);
    localparam logic [2:0]  LAST_DIGIT = 3'(NUM_DIGITS - 1);
    localparam logic [2:0]  DP_DIGIT   = 3'd4;

    logic [SLOT_W-1:0] slot_q [NUM_SLOTS];
    logic [7:0]        valid_q, valid_d;
    logic [15:0]       cap_q, cap_d;
    logic [19:0]       pre_q, pre_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        sel_q, sel_d;
    logic [7:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic              capture_s;
    logic [SLOT_W-1:0] cur_slot_s;
    logic              cur_valid_s;
    logic [3:0]        nibble_s;
    logic [6:0]        glyph_s;

    // Next-state for capture bookkeeping, prescaler and digit/frame scan.
    always_comb begin
        capture_s = outdisplay & ~freeze;
        valid_d   = valid_q;
        cap_d     = cap_q;
        if (capture_s) begin
            valid_d = valid_q | (8'b0000_0001 << outsel);
            cap_d   = cap_q + 16'd1;
        end else begin
            valid_d = valid_q;
            cap_d   = cap_q;
        end

        idx_d = idx_q;
        sel_d = sel_q;
        if (pre_q == PRE_LAST) begin
            pre_d = 20'd0;
            if (idx_q == LAST_DIGIT) begin
                // A new frame latches the switches so no frame mixes two slots.
                idx_d = 3'd0;
                sel_d = disp_sel;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end else begin
            pre_d = pre_q + 20'd1;
        end
    end

    // Select the nibble of the displayed slot for the current digit.
    always_comb begin
        cur_slot_s  = slot_q[sel_q];
        cur_valid_s = valid_q[sel_q];
        nibble_s    = cur_slot_s[{idx_q, 2'b00} +: 4];
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (nibble_s),
        .seg_n_o  (glyph_s)
    );

    // Next values for the registered pin drivers.
    always_comb begin
        an_d = digit_enable_n(idx_q);
        if (cur_valid_s) begin
            seg_d = glyph_s;
            dp_d  = (idx_q != DP_DIGIT);
        end else begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end
    end

    // Slot bank write port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else if (capture_s) begin
            slot_q[outsel] <= {outval1, outval2};
        end
    end

    // Control state and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 8'h00;
            cap_q   <= 16'h0000;
            pre_q   <= 20'd0;
            idx_q   <= 3'd0;
            sel_q   <= 3'd0;
            an_q    <= 8'hFF;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            valid_q <= valid_d;
            cap_q   <= cap_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an_n       = an_q;
    assign seg_n      = seg_q;
    assign dp_n       = dp_q;
    assign slot_valid = valid_q;
    assign cap_count  = cap_q;

endmodule

// File: tb/tb_out_display_unit.sv
// Scoreboard bench for out_display_unit at SCAN_DIV=2: stimulus queues the
// expected digit stream, a monitor pops and compares on every new digit.
module tb_out_display_unit;

    logic        clock;
    logic        reset_n;
    logic [15:0] outval1;
    logic [15:0] outval2;
    logic [2:0]  outsel;
    logic        outdisplay;
    logic        freeze;
    logic [2:0]  disp_sel;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [7:0]  an_n;
    logic [7:0]  slot_valid;
    logic [15:0] cap_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    typedef struct {
        int         tag;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];

    out_display_unit #(.SCAN_DIV(2), .NUM_DIGITS(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .outval1    (outval1),
        .outval2    (outval2),
        .outsel     (outsel),
        .outdisplay (outdisplay),
        .freeze     (freeze),
        .disp_sel   (disp_sel),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .slot_valid (slot_valid),
        .cap_count  (cap_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int frame, input logic [31:0] val, input bit valid);
        exp_t e;
        logic [31:0] v;
        v = val;
        for (int d = 0; d < 8; d++) begin
            e.tag = frame * 8 + d;
            e.an  = ~(8'b0000_0001 << d);
            e.seg = valid ? glyph(v[4*d +: 4]) : 7'h7F;
            e.dp  = !(valid && d == 4);
            exp_q.push_back(e);
        end
    endtask

    task automatic at_neg(input int e);
        @(negedge clock);
        while (cyc < e) @(negedge clock);
    endtask

    task automatic strobe_set(input logic [2:0] sel, input logic [15:0] v1, input logic [15:0] v2);
        outsel = sel; outval1 = v1; outval2 = v2; outdisplay = 1'b1;
    endtask

    // Monitor: every digit change is one scoreboard transaction.
    initial begin : monitor
        logic [7:0] prev_an;
        int         digit;
        exp_t       e;
        prev_an = 8'hFF;
        digit   = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_an = 8'hFF;
                digit   = 0;
            end else if (an_n !== prev_an) begin
                prev_an = an_n;
                while (exp_q.size() > 0 && exp_q[0].tag < digit) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL missed_digit tag %0d: got none expected an %h", exp_q[0].tag, exp_q[0].an);
                    void'(exp_q.pop_front());
                end
                if (exp_q.size() > 0 && exp_q[0].tag == digit) begin
                    e = exp_q.pop_front();
                    chk($sformatf("an_n tag%0d", digit), 32'(an_n), 32'(e.an));
                    chk($sformatf("seg_n tag%0d", digit), 32'(seg_n), 32'(e.seg));
                    chk($sformatf("dp_n tag%0d", digit), 32'(dp_n), 32'(e.dp));
                end
                digit++;
            end
        end
    end

    initial begin : stimulus
        reset_n = 1'b0; outval1 = 16'h0; outval2 = 16'h0; outsel = 3'd0;
        outdisplay = 1'b0; freeze = 1'b0; disp_sel = 3'd0;
        repeat (3) @(negedge clock);
        chk("reset an_n", 32'(an_n), 32'h0FF);
        chk("reset seg_n", 32'(seg_n), 32'h07F);
        chk("reset dp_n", 32'(dp_n), 32'h1);
        chk("reset slot_valid", 32'(slot_valid), 32'h00);
        chk("reset cap_count", 32'(cap_count), 32'h0);

        push_frame(0, 32'h0, 1'b0);
        push_frame(1, 32'h1234ABCD, 1'b1);
        reset_n = 1'b1;

        at_neg(9);
        chk("blank d4 an_n", 32'(an_n), 32'h0EF);
        chk("blank d4 dp_n", 32'(dp_n), 32'h1);
        chk("blank d4 seg_n", 32'(seg_n), 32'h07F);

        at_neg(15); strobe_set(3'd0, 16'h1234, 16'hABCD);
        at_neg(16); outdisplay = 1'b0;
        chk("cap1 slot_valid", 32'(slot_valid), 32'h01);
        chk("cap1 cap_count", 32'(cap_count), 32'd1);

        at_neg(17);
        chk("glyph D an_n", 32'(an_n), 32'h0FE);
        chk("glyph D seg_n", 32'(seg_n), 32'b0100001);
        strobe_set(3'd3, 16'h0001, 16'h0002);
        at_neg(18); strobe_set(3'd3, 16'h0003, 16'h0004);
        at_neg(19); strobe_set(3'd5, 16'h0005, 16'h0006);
        at_neg(20); outdisplay = 1'b0;
        chk("b2b slot_valid", 32'(slot_valid), 32'h29);
        chk("b2b cap_count", 32'(cap_count), 32'd4);

        at_neg(21); freeze = 1'b1; strobe_set(3'd2, 16'hDEAD, 16'hBEEF);
        at_neg(22); outdisplay = 1'b0; freeze = 1'b0;
        chk("freeze slot_valid", 32'(slot_valid), 32'h29);
        chk("freeze cap_count", 32'(cap_count), 32'd4);
        at_neg(23); strobe_set(3'd2, 16'hCAFE, 16'hF00D);
        at_neg(24); outdisplay = 1'b0;
        chk("unfreeze slot_valid", 32'(slot_valid), 32'h2D);
        chk("unfreeze cap_count", 32'(cap_count), 32'd5);

        at_neg(25);
        chk("d4 an_n", 32'(an_n), 32'h0EF);
        chk("d4 seg_n", 32'(seg_n), 32'h19);
        chk("d4 dp_n", 32'(dp_n), 32'h0);
        disp_sel = 3'd3; push_frame(2, 32'h00030004, 1'b1);
        at_neg(27);
        chk("d5 dp_n", 32'(dp_n), 32'h1);
        chk("d5 seg_n", 32'(seg_n), 32'h30);

        at_neg(34); disp_sel = 3'd2; push_frame(3, 32'hCAFEF00D, 1'b1);
        at_neg(50); disp_sel = 3'd0; push_frame(4, 32'h1234ABCD, 1'b1);
        at_neg(70); disp_sel = 3'd5; push_frame(5, 32'h00050006, 1'b1);

        at_neg(96); strobe_set(3'd7, 16'h7777, 16'h0000);
        at_neg(96 + 65530); outdisplay = 1'b0;
        chk("cap_count max", 32'(cap_count), 32'hFFFF);
        at_neg(96 + 65531); outdisplay = 1'b1;
        at_neg(96 + 65532); outdisplay = 1'b0;
        chk("cap_count wrap", 32'(cap_count), 32'h0000);
        chk("wrap slot_valid", 32'(slot_valid), 32'hAD);

        @(posedge clock); #3;
        reset_n = 1'b0;
        #1;
        chk("async reset an_n", 32'(an_n), 32'h0FF);
        chk("async reset seg_n", 32'(seg_n), 32'h07F);
        chk("async reset dp_n", 32'(dp_n), 32'h1);
        chk("async reset slot_valid", 32'(slot_valid), 32'h00);
        chk("async reset cap_count", 32'(cap_count), 32'h0);
        push_frame(0, 32'h0, 1'b0);
        @(negedge clock);
        @(negedge clock); reset_n = 1'b1;
        at_neg(20);

        while (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL leftover tag %0d: got none expected an %h", exp_q[0].tag, exp_q[0].an);
            void'(exp_q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
